// File: rtl/replay_player.sv
// Replay buffer playback engine: fetches one signed sample per sample_tick from
// replay RAM port B and presents it to the DAC/mixer path.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | not playing; waits for play
// S_ARMED | playing; waits for the next sample_tick
// S_FETCH | ram_re issued at addr
// S_WAIT  | ram_data valid; captured, then advance, wrap or finish
module replay_player #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         play,
    input  logic                         stop,
    input  logic                         loop_en,
    input  logic        [ADDR_WIDTH-1:0] end_addr,
    input  logic                         sample_tick,
    output logic        [ADDR_WIDTH-1:0] ram_addr,
    output logic                         ram_re,
    input  logic signed [DATA_WIDTH-1:0] ram_data,
    output logic signed [DATA_WIDTH-1:0] sample_out,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         tick_miss
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_FETCH,
        S_WAIT
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   end_q;
    logic                    at_end;
    logic                    start;

    assign at_end   = (addr == end_q);
    assign start    = (state == S_IDLE) && play && !stop;
    assign ram_addr = addr;
    assign ram_re   = (state == S_FETCH);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ARMED;
            S_ARMED: begin
                if (stop)             state_nxt = S_IDLE;
                else if (sample_tick) state_nxt = S_FETCH;
            end
            S_FETCH: state_nxt = stop ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (stop || (at_end && !loop_en)) state_nxt = S_IDLE;
                else                              state_nxt = S_ARMED;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= '0;
            end_q        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            tick_miss    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;

            if (start) begin
                end_q     <= end_addr;
                addr      <= '0;
                tick_miss <= 1'b0;
            end

            // A tick while a fetch is outstanding is dropped, only flagged.
            if (sample_tick && (state == S_FETCH || state == S_WAIT)) begin
                tick_miss <= 1'b1;
            end

            if (stop && state != S_IDLE) begin
                sample_out <= '0;
            end else if (state == S_WAIT) begin
                sample_out   <= ram_data;
                sample_valid <= 1'b1;
                if (!at_end) begin
                    addr <= addr + 1'b1;
                end else if (loop_en) begin
                    addr <= '0;
                end else begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/replay_player.md
# replay_player

Playback engine for the replay buffer: on `play` it reads signed 16-bit samples sequentially from port B of the replay RAM, starting at address 0, one sample per `sample_tick`, and presents each sample to the audio output path. It sits between the replay RAM's read port and the DAC/mixer stage. It supports one-shot or looped playback, immediate stop, and a sticky flag for missed ticks.

## Interface

- `ADDR_WIDTH`, 17, replay RAM address width.
- `DATA_WIDTH`, 16, sample width (signed).

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `play`  in  1  single-cycle start request.
- `stop`  in  1  single-cycle abort request.
- `loop_en`  in  1  wrap to address 0 at end of buffer; sampled live at each end-of-buffer.
- `end_addr`  in  ADDR_WIDTH  last sample address to play (inclusive); latched on accepted `play`.
- `sample_tick`  in  1  audio-rate strobe (e.g. 48 kHz), one cycle wide.
- `ram_addr`  out  ADDR_WIDTH  read address to the replay RAM port B.
- `ram_re`  out  1  read enable to the replay RAM port B; one-cycle pulse.
- `ram_data`  in signed  DATA_WIDTH  port B read data, valid one cycle after `ram_re`.
- `sample_out`  out signed  DATA_WIDTH  current output sample, held between updates.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `busy`  out  1  high from the cycle after `play` until playback ends.
- `done`  out  1  one-cycle pulse on natural (non-looped) end of buffer.
- `tick_miss`  out  1  sticky; a `sample_tick` arrived while a fetch was in flight. Cleared by `rst` or an accepted `play`.

## Operation

- All outputs reset to 0. After reset the state is IDLE and the internal address and latched end address are 0.
- States:
  - IDLE: `busy`=0. An accepted `play` latches `end_addr`, sets addr=0, clears `tick_miss`, and goes to ARMED.
  - ARMED: `busy`=1. On `sample_tick`, go to FETCH.
  - FETCH: `ram_re`=1 and `ram_addr`=addr for exactly this cycle. Next state is WAIT.
  - WAIT: `ram_data` is valid. Register `sample_out`<=`ram_data` and assert `sample_valid` next cycle.
    - If addr≠end: addr<=addr+1 and return to ARMED.
    - If addr==end and `loop_en`=1: addr<=0 and return to ARMED.
    - Otherwise: pulse `done` next cycle and go to IDLE.
- `ram_addr` always reflects the internal addr, including outside FETCH. `ram_re` is high only in FETCH.
- `play` is ignored when not in IDLE (no restart). `stop` takes priority over `play` in the same cycle.
- `stop` in any non-IDLE state:
  - Go to IDLE next cycle.
  - `sample_out` is forced to 0 (mute), `sample_valid` stays 0, and `done` is not pulsed.
  - A RAM read already issued in FETCH is discarded.
- `sample_tick` in FETCH or WAIT sets `tick_miss`; the tick is dropped and not queued. Ticks in IDLE are ignored and do not set `tick_miss`.
- `end_addr`=0 plays exactly one sample. `end_addr`=2^ADDR_WIDTH−1 plays the full RAM. The address never wraps except via `loop_en`.
- `rst` mid-playback returns to IDLE with all outputs 0 on the next cycle. Any in-flight read is discarded.
- This block never writes the RAM. Its port B write enable is tied low at the integration level.

## Timing

- `play` at cycle P puts `busy` high at P+1 (ARMED).
- `sample_tick` in ARMED at cycle T gives:
  - T+1: `ram_re`=1 at `ram_addr`=n.
  - T+2: `ram_data` is sample n.
  - T+3: `sample_out`=mem[n] and `sample_valid`=1.
- Tick-to-sample latency is 3 cycles. The state is back in ARMED at T+3, so a tick at T+3 is accepted.
- Minimum tick spacing is 3 cycles; ticks at T+1 or T+2 set `tick_miss`.
- Final non-looped sample: `done`=1 and `busy`=0 at T+3, together with the last `sample_valid`.
- `stop` at cycle S gives `busy`=0 and `sample_out`=0 at S+1.

## Test plan

- Preload mem[0..3]={100,−200,300,−400}, `end_addr`=3, `loop_en`=0, `play`, ticks every 10 cycles → `sample_valid` pulses carrying 100,−200,300,−400, each 3 cycles after its tick; `done` and `busy` fall with the 4th sample; a further tick produces no `ram_re`.
- Same preload with `loop_en`=1 and 6 ticks → samples 100,−200,300,−400,100,−200; `done` never pulses; `ram_addr` returns to 0 after 3.
- `end_addr`=0 with mem[0]=0x7FFF → a single `sample_out`=32767 and `done` at T+3.
- Ticks at T and T+2 during playback → `tick_miss`=1 and only one sample is produced. A new `play` after completion clears `tick_miss`.
- `stop` asserted in the FETCH cycle → `busy`=0 and `sample_out`=0 next cycle, no `sample_valid`, no `done`. `play`+`stop` in the same cycle from IDLE → stays IDLE.
- `rst` asserted in WAIT → all outputs 0 next cycle. A subsequent `play` restarts from address 0.
